// File: rtl/rtype_ctrl_fsm.sv
// Multi-cycle R-type control sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK, with TRAP for illegal encodings.
// Optional retired-instruction counter enabled by defining RTYPE_CTRL_PERF_CNT_EN.
module rtype_ctrl_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [6:0]            alu_control,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [4:0]            wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  reg_we,
    output logic                  pc_en,
    output logic                  illegal_instr,
    input  logic                  trap_ack,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  retired_count
);

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t                r_state;
    logic [31:0]           r_instr;
    logic                  r_ready;
    logic                  r_busy;
    logic [6:0]            r_alu_ctrl;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_reg_we;
    logic                  r_pc_en;
    logic                  r_illegal;

    logic [6:0]            w_alu_code;
    logic                  w_legal;

    // Code 0 doubles as the "illegal" marker, so legality falls out of the decode.
    always_comb begin
        w_alu_code = 7'd0;
        if (r_instr[6:0] == OPC_RTYPE) begin
            case ({r_instr[31:25], r_instr[14:12]})
                {7'b0000000, 3'b000}: w_alu_code = 7'd1;
                {7'b0100000, 3'b000}: w_alu_code = 7'd2;
                {7'b0000000, 3'b001}: w_alu_code = 7'd3;
                {7'b0000000, 3'b010}: w_alu_code = 7'd4;
                {7'b0000000, 3'b011}: w_alu_code = 7'd5;
                {7'b0000000, 3'b100}: w_alu_code = 7'd6;
                {7'b0000000, 3'b101}: w_alu_code = 7'd7;
                {7'b0100000, 3'b101}: w_alu_code = 7'd8;
                {7'b0000000, 3'b110}: w_alu_code = 7'd9;
                {7'b0000000, 3'b111}: w_alu_code = 7'd10;
                default:              w_alu_code = 7'd0;
            endcase
        end
    end
    assign w_legal = (w_alu_code != 7'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_alu_ctrl <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_reg_we   <= 1'b0;
            r_pc_en    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised only on entry to WRITEBACK.
            r_reg_we <= 1'b0;
            r_pc_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr <= instr;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_rs1      <= r_instr[19:15];
                    r_rs2      <= r_instr[24:20];
                    r_wb_addr  <= r_instr[11:7];
                    r_alu_ctrl <= w_alu_code;
                    if (w_legal) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end
                end
                S_EXECUTE: begin
                    r_wb_data <= alu_result;
                    r_pc_en   <= 1'b1;
                    r_reg_we  <= (r_wb_addr != 5'd0);
                    r_state   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_TRAP: begin
                    if (trap_ack) begin
                        r_illegal <= 1'b0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RTYPE_CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_retired <= r_retired + CNT_WIDTH'(1);
        end
    end
    assign retired_count = r_retired;
`else
    assign retired_count = '0;
`endif

    assign instr_ready   = r_ready;
    assign busy          = r_busy;
    assign alu_control   = r_alu_ctrl;
    assign rs1_addr      = r_rs1;
    assign rs2_addr      = r_rs2;
    assign wb_addr       = r_wb_addr;
    assign wb_data       = r_wb_data;
    assign reg_we        = r_reg_we;
    assign pc_en         = r_pc_en;
    assign illegal_instr = r_illegal;

endmodule
